// File: rtl/microsequencer_stack_if.sv
// Bundle of the sequencer's decode, condition, microstore-load and status signals.
// Optional macro MSEQ_STALL_EN adds the stall line.
interface microsequencer_stack_if #(
   parameter int ADDR_W      = 7,
   parameter int CTRL_W      = 26,
   parameter int NCOND       = 4,
   parameter int STACK_DEPTH = 4
);
   localparam int CSEL_W = (NCOND > 1) ? $clog2(NCOND) : 1;
   localparam int WORD_W = 3 + 1 + CSEL_W + CTRL_W + ADDR_W;
   localparam int SP_W   = $clog2(STACK_DEPTH + 1);

   logic [ADDR_W-1:0] decode_addr;
   logic [NCOND-1:0]  cond;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [WORD_W-1:0] ld_data;
   logic [CTRL_W-1:0] ctrl_out;
   logic [ADDR_W-1:0] upc;
   logic [SP_W-1:0]   sp;
   logic              stk_ovf;
   logic              stk_unf;
`ifdef MSEQ_STALL_EN
   logic              stall;
`endif

   modport master (
      output decode_addr, cond, ld_en, ld_addr, ld_data,
`ifdef MSEQ_STALL_EN
      output stall,
`endif
      input  ctrl_out, upc, sp, stk_ovf, stk_unf
   );

   modport slave (
      input  decode_addr, cond, ld_en, ld_addr, ld_data,
`ifdef MSEQ_STALL_EN
      input  stall,
`endif
      output ctrl_out, upc, sp, stk_ovf, stk_unf
   );
endinterface

// File: rtl/microsequencer_stack.sv
// Microprogrammed sequencer: writable microstore, registered microword and return-address stack.
// Optional macro MSEQ_STALL_EN adds a stall input that freezes the sequencer state.
module microsequencer_stack #(
   parameter int ADDR_W      = 7,
   parameter int CTRL_W      = 26,
   parameter int NCOND       = 4,
   parameter int STACK_DEPTH = 4
) (
   input logic                   clk,
   input logic                   reset,
   microsequencer_stack_if.slave bus
);
   localparam int CSEL_W = (NCOND > 1) ? $clog2(NCOND) : 1;
   localparam int WORD_W = 3 + 1 + CSEL_W + CTRL_W + ADDR_W;
   localparam int SP_W   = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   typedef enum logic [2:0] {
      OP_DECODE = 3'd0,
      OP_HOLD   = 3'd1,
      OP_JUMP   = 3'd2,
      OP_INC    = 3'd3,
      OP_CJUMP  = 3'd4,
      OP_CWAIT  = 3'd5,
      OP_CALL   = 3'd6,
      OP_RET    = 3'd7
   } op_e;

   typedef struct packed {
      op_e               op;
      logic              inv;
      logic [CSEL_W-1:0] csel;
      logic [CTRL_W-1:0] ctrl;
      logic [ADDR_W-1:0] target;
   } uword_t;

   logic [WORD_W-1:0] mem   [DEPTH];
   logic [ADDR_W-1:0] stack [STACK_DEPTH];

   uword_t            cr;
   uword_t            fetch_word;
   logic [ADDR_W-1:0] upc_q, upc_inc, next_addr, fetch_addr;
   logic [SP_W-1:0]   sp_q, sp_next;
   logic [IDX_W-1:0]  top_idx, push_idx;
   logic              ovf_q, unf_q;
   logic              sel_cond, sts, push, overflow, underflow, hold;

`ifdef MSEQ_STALL_EN
   assign hold = bus.stall;
`else
   assign hold = 1'b0;
`endif

   assign upc_inc  = upc_q + ADDR_W'(1);
   assign top_idx  = IDX_W'(sp_q - SP_W'(1));
   assign push_idx = IDX_W'(sp_q);

   // Condition selects beyond the implemented inputs read as 0.
   always_comb begin
      sel_cond = 1'b0;
      if (int'(cr.csel) < NCOND) sel_cond = bus.cond[cr.csel];
   end
   assign sts = sel_cond ^ cr.inv;

   // NOTE: every output of this block gets a default first, so no path can leave a latch.
   always_comb begin
      next_addr = upc_inc;
      sp_next   = sp_q;
      push      = 1'b0;
      overflow  = 1'b0;
      underflow = 1'b0;
      case (cr.op)
         OP_DECODE: next_addr = bus.decode_addr;
         OP_HOLD:   next_addr = upc_q;
         OP_JUMP:   next_addr = cr.target;
         OP_INC:    ;
         OP_CJUMP:  if (sts) next_addr = cr.target;
         OP_CWAIT:  if (!sts) next_addr = upc_q;
         OP_CALL: begin
            next_addr = cr.target;
            if (sp_q == SP_FULL) begin
               overflow = 1'b1;
            end else begin
               push    = 1'b1;
               sp_next = sp_q + SP_W'(1);
            end
         end
         OP_RET: begin
            if (sp_q == '0) begin
               next_addr = '0;
               underflow = 1'b1;
            end else begin
               next_addr = stack[top_idx];
               sp_next   = sp_q - SP_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Write-first: a load hitting the address being fetched wins over the stored word.
   always_comb begin
      fetch_addr = next_addr;
      if (reset)     fetch_addr = '0;
      else if (hold) fetch_addr = upc_q;
      if (bus.ld_en && (bus.ld_addr == fetch_addr)) fetch_word = uword_t'(bus.ld_data);
      else                                          fetch_word = uword_t'(mem[fetch_addr]);
   end

   // NOTE: the microstore is storage, not state; it is left out of reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (bus.ld_en) mem[bus.ld_addr] <= bus.ld_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      cr <= fetch_word;
      if (reset) begin
         upc_q <= '0;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (!hold) begin
         upc_q <= next_addr;
         sp_q  <= sp_next;
         ovf_q <= ovf_q | overflow;
         unf_q <= unf_q | underflow;
         if (push) stack[push_idx] <= upc_inc;
      end
   end

   assign bus.ctrl_out = cr.ctrl;
   assign bus.upc      = upc_q;
   assign bus.sp       = sp_q;
   assign bus.stk_ovf  = ovf_q;
   assign bus.stk_unf  = unf_q;

endmodule
